// File: rtl/vga_box_renderer.sv
// Bouncing solid box on a black background, registered 8-bit RGB for the VGA DAC.
// Optional 1-pixel white frame around the active area when VGA_BOX_BORDER_EN is defined.
module vga_box_renderer #(
    parameter int HVALID    = 640,
    parameter int VVALID    = 480,
    parameter int HMAX      = 800,
    parameter int BOX       = 32,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic       PIX_EN,
    input  logic [9:0] HCNT,
    input  logic [9:0] VCNT,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       FRAME_TICK
);
    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FW-1:0] FDM1 = FW'(FRAME_DIV - 1);
    localparam logic [10:0] HV11   = 11'(HVALID);
    localparam logic [10:0] VV11   = 11'(VVALID);
    localparam logic [10:0] BOX11  = 11'(BOX);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [9:0]  HLAST  = 10'(HMAX - 1);
    localparam logic [9:0]  VLAST  = 10'(VVALID - 1);

    logic [9:0]    bx_q, bx_d, by_q, by_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          tick_q;

    logic          eof;
    logic [11:0]   xs, ys;
    logic [10:0]   hc, vc, bx11, by11;
    logic          in_act, in_box;
    logic [23:0]   box_rgb;

    // Returns {next position, next direction, wall hit} for one axis.
    function automatic logic [11:0] step_axis(input logic [9:0] p, input logic d,
                                              input logic [10:0] lim);
        logic [10:0] pe;
        logic [10:0] np;
        logic        nd, hit;
        pe  = {1'b0, p};
        np  = pe;
        nd  = d;
        hit = 1'b0;
        if (d) begin
            if (pe + STEP11 + BOX11 >= lim) begin
                np  = lim - BOX11;
                nd  = 1'b0;
                hit = 1'b1;
            end else begin
                np = pe + STEP11;
            end
        end else begin
            if (pe <= STEP11) begin
                np  = '0;
                nd  = 1'b1;
                hit = 1'b1;
            end else begin
                np = pe - STEP11;
            end
        end
        return {np[9:0], nd, hit};
    endfunction

    assign eof = PIX_EN && (HCNT == HLAST) && (VCNT == VLAST);
    assign xs  = step_axis(bx_q, dx_q, HV11);
    assign ys  = step_axis(by_q, dy_q, VV11);

    // Position moves only at end of frame, which falls in blanking, so no frame tears.
    always_comb begin
        bx_d   = bx_q;
        by_d   = by_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
        cidx_d = cidx_q;
        fcnt_d = fcnt_q;
        if (eof) begin
            if (fcnt_q == FDM1) begin
                fcnt_d = '0;
                bx_d   = xs[11:2];
                dx_d   = xs[1];
                by_d   = ys[11:2];
                dy_d   = ys[1];
                if (xs[0] || ys[0])
                    cidx_d = (cidx_q == 2'd2) ? 2'd0 : cidx_q + 2'd1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign hc     = {1'b0, HCNT};
    assign vc     = {1'b0, VCNT};
    assign bx11   = {1'b0, bx_q};
    assign by11   = {1'b0, by_q};
    assign in_act = (hc < HV11) && (vc < VV11);
    assign in_box = (hc >= bx11) && (hc < bx11 + BOX11) && (vc >= by11) && (vc < by11 + BOX11);

    always_comb begin
        case (cidx_q)
            2'd0:    box_rgb = 24'hFF0000;
            2'd1:    box_rgb = 24'h00FF00;
            default: box_rgb = 24'h0000FF;
        endcase
    end

    always_comb begin
        rgb_d = rgb_q;
        if (PIX_EN) begin
            rgb_d = 24'h000000;
            if (in_act && in_box)
                rgb_d = box_rgb;
`ifdef VGA_BOX_BORDER_EN
            else if (in_act && (HCNT == 10'd0 || hc == HV11 - 11'd1 ||
                                VCNT == 10'd0 || vc == VV11 - 11'd1))
                rgb_d = 24'hFFFFFF;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            bx_q   <= '0;
            by_q   <= '0;
            dx_q   <= 1'b1;
            dy_q   <= 1'b1;
            cidx_q <= '0;
            fcnt_q <= '0;
            rgb_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            bx_q   <= bx_d;
            by_q   <= by_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            cidx_q <= cidx_d;
            fcnt_q <= fcnt_d;
            rgb_q  <= rgb_d;
            tick_q <= eof;
        end
    end

    assign VGA_R      = rgb_q[23:16];
    assign VGA_G      = rgb_q[15:8];
    assign VGA_B      = rgb_q[7:0];
    assign FRAME_TICK = tick_q;
endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: default build, a 64x64 corner build and a FRAME_DIV=3 build.
module tb_vga_box_renderer;
    localparam logic [23:0] RED = 24'hFF0000, GRN = 24'h00FF00, BLU = 24'h0000FF;
    localparam logic [23:0] BLK = 24'h000000, WHT = 24'hFFFFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       pe [3];
    logic [9:0] hc [3];
    logic [9:0] vc [3];
    logic [7:0] r [3];
    logic [7:0] g [3];
    logic [7:0] b [3];
    logic       tk [3];
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    vga_box_renderer u_def (
        .CLOCK_50(clk), .RST(rst), .PIX_EN(pe[0]), .HCNT(hc[0]), .VCNT(vc[0]),
        .VGA_R(r[0]), .VGA_G(g[0]), .VGA_B(b[0]), .FRAME_TICK(tk[0]));

    vga_box_renderer #(.HVALID(64), .VVALID(64), .HMAX(80), .BOX(8), .STEP(2), .FRAME_DIV(1)) u_small (
        .CLOCK_50(clk), .RST(rst), .PIX_EN(pe[1]), .HCNT(hc[1]), .VCNT(vc[1]),
        .VGA_R(r[1]), .VGA_G(g[1]), .VGA_B(b[1]), .FRAME_TICK(tk[1]));

    vga_box_renderer #(.FRAME_DIV(3)) u_div (
        .CLOCK_50(clk), .RST(rst), .PIX_EN(pe[2]), .HCNT(hc[2]), .VCNT(vc[2]),
        .VGA_R(r[2]), .VGA_G(g[2]), .VGA_B(b[2]), .FRAME_TICK(tk[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] col(input int i);
        return {r[i], g[i], b[i]};
    endfunction

    // One CLOCK_50 cycle presenting counters; returns #1 after the edge.
    task automatic px(input int i, input int h, input int v, input logic en);
        hc[i] = 10'(h);
        vc[i] = 10'(v);
        pe[i] = en;
        @(posedge clk);
        #1;
        pe[i] = 1'b0;
    endtask

    task automatic chkpx(input string tag, input int i, input int h, input int v, input logic [23:0] exp);
        px(i, h, v, 1'b1);
        chk(tag, {8'h0, col(i)}, {8'h0, exp});
    endtask

    task automatic eof(input int i);
        if (i == 1) px(i, 79, 63, 1'b1);
        else        px(i, 799, 479, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pe[i] = 1'b0;
            hc[i] = '0;
            vc[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", {8'h0, col(0)}, 32'h0);
        chk("rst_tick", {31'h0, tk[0]}, 32'h0);
        rst = 1'b0;

        chkpx("box_5_5", 0, 5, 5, RED);
        chkpx("bg_40_5", 0, 40, 5, BLK);
        chkpx("hblank", 0, 700, 10, BLK);
        chkpx("vblank", 0, 0, 490, BLK);

        // RGB holds while PIX_EN is low
        px(0, 5, 5, 1'b0);
        chk("hold_blk", {8'h0, col(0)}, {8'h0, BLK});
        chkpx("box_again", 0, 5, 5, RED);
        px(0, 40, 5, 1'b0);
        chk("hold_red", {8'h0, col(0)}, {8'h0, RED});

        // EOF counters without PIX_EN are ignored
        px(0, 799, 479, 1'b0);
        chk("noen_tick", {31'h0, tk[0]}, 32'h0);
        chkpx("noen_nomove", 0, 0, 0, RED);

        eof(0);
        chk("eof1_tick", {31'h0, tk[0]}, 32'h1);
        px(0, 0, 0, 1'b0);
        chk("eof1_tick_clr", {31'h0, tk[0]}, 32'h0);
        chkpx("m1_1_1", 0, 1, 1, BLK);
        chkpx("m1_2_2", 0, 2, 2, RED);
        chkpx("m1_33_33", 0, 33, 33, RED);
        chkpx("m1_34_2", 0, 34, 2, BLK);

        // Asynchronous reset mid-frame
        chkpx("pre_rst", 0, 2, 2, RED);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rgb", {8'h0, col(0)}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        eof(0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tick", {31'h0, tk[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chkpx("post_rst_0_0", 0, 0, 0, RED);
        chkpx("post_rst_5_5", 0, 5, 5, RED);

        // Y wall hit at update 224 turns the box green; X reaches 606 at update 303
        for (int k = 0; k < 303; k++) eof(0);
        chkpx("u303_in", 0, 606, 290, GRN);
        chkpx("u303_left", 0, 605, 290, BLK);
        eof(0);
        chkpx("u304_in", 0, 608, 288, BLU);
        chkpx("u304_edge", 0, 639, 288, BLU);
        chkpx("u304_left", 0, 607, 288, BLK);
        eof(0);
        chkpx("u305_in", 0, 606, 286, BLU);
        chkpx("u305_right", 0, 637, 286, BLU);
        chkpx("u305_out", 0, 638, 286, BLK);

`ifdef VGA_BOX_BORDER_EN
        chkpx("brd_0_100", 0, 0, 100, WHT);
        chkpx("brd_639_479", 0, 639, 479, WHT);
`else
        chkpx("brd_0_100", 0, 0, 100, BLK);
        chkpx("brd_639_479", 0, 639, 479, BLK);
`endif
        chkpx("brd_1_100", 0, 1, 100, BLK);

        // Corner build: 64x64 area, 8-pixel box
        for (int k = 0; k < 27; k++) eof(1);
        chkpx("c27_in", 1, 54, 54, RED);
        chkpx("c27_out", 1, 53, 54, BLK);
        eof(1);
        chkpx("c28_in", 1, 56, 56, GRN);
        chkpx("c28_far", 1, 63, 63, GRN);
        chkpx("c28_out", 1, 55, 56, BLK);
        for (int k = 0; k < 27; k++) eof(1);
        chkpx("c55_in", 1, 2, 2, GRN);
        chkpx("c55_out", 1, 1, 2, BLK);
        eof(1);
        chkpx("c56_org", 1, 0, 0, BLU);
        chkpx("c56_far", 1, 7, 7, BLU);
        chkpx("c56_out", 1, 8, 0, BLK);

        // Frame divider of 3
        eof(2);
        chk("div_tick1", {31'h0, tk[2]}, 32'h1);
        chkpx("div_e1", 2, 0, 0, RED);
        eof(2);
        chk("div_tick2", {31'h0, tk[2]}, 32'h1);
        chkpx("div_e2", 2, 0, 0, RED);
        eof(2);
        chkpx("div_e3_old", 2, 0, 0, BLK);
        chkpx("div_e3_new", 2, 2, 2, RED);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
